// File: rtl/vedic_seq_mul8.sv
// Sequential OP_W x OP_W multiplier that reuses one 4x4 Vedic core over all nibble pairs.
// Define VEDIC_SEQ_BACK2BACK_EN to let DONE hand off directly to CALC (no bubble cycle).

module vedic2mul (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic cross_lo;
    logic cross_hi;
    logic carry;

    always_comb begin
        cross_lo = a[1] & b[0];
        cross_hi = a[0] & b[1];
        carry    = cross_lo & cross_hi;
        p[0]     = a[0] & b[0];
        p[1]     = cross_lo ^ cross_hi;
        p[2]     = (a[1] & b[1]) ^ carry;
        p[3]     = (a[1] & b[1]) & carry;
    end
endmodule

module vedic4mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] q_ll;
    logic [3:0] q_hl;
    logic [3:0] q_lh;
    logic [3:0] q_hh;
    logic [5:0] s_mid;
    logic [3:0] s_top;

    vedic2mul u_ll (.a(a[1:0]), .b(b[1:0]), .p(q_ll));
    vedic2mul u_hl (.a(a[3:2]), .b(b[1:0]), .p(q_hl));
    vedic2mul u_lh (.a(a[1:0]), .b(b[3:2]), .p(q_lh));
    vedic2mul u_hh (.a(a[3:2]), .b(b[3:2]), .p(q_hh));

    // Crosswise partials land at weight 4; s_top cannot overflow since the product fits 8 bits.
    always_comb begin
        s_mid  = {2'b00, q_hl} + {2'b00, q_lh} + {4'b0000, q_ll[3:2]};
        s_top  = q_hh + s_mid[5:2];
        p      = {s_top, s_mid[1:0], q_ll[1:0]};
    end
endmodule

module vedic_seq_mul8 #(
    parameter int unsigned OP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*OP_W-1:0] p,
    output logic              busy
);
    localparam int unsigned NIB   = OP_W / 4;
    localparam int unsigned PAIRS = NIB * NIB;
    localparam int unsigned KW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int unsigned AW    = 2 * OP_W;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [OP_W-1:0] ra_q, ra_d;
    logic [OP_W-1:0] rb_q, rb_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [AW-1:0]   p_q, p_d;
    logic [KW-1:0]   k_q, k_d;

    logic            accept;
    logic            last_pair;
    int unsigned     idx_i;
    int unsigned     idx_j;
    logic [3:0]      nib_a;
    logic [3:0]      nib_b;
    logic [7:0]      prod8;
    logic [AW-1:0]   prod_ext;
    logic [AW-1:0]   sum;

    vedic4mul u_core (.a(nib_a), .b(nib_b), .p(prod8));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ra_q    <= '0;
            rb_q    <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        idx_i     = 32'(k_q) % NIB;
        idx_j     = 32'(k_q) / NIB;
        nib_a     = ra_q[4*idx_i +: 4];
        nib_b     = rb_q[4*idx_j +: 4];
        prod_ext  = '0;
        prod_ext[7:0] = prod8;
        sum       = acc_q + (prod_ext << (4 * (idx_i + idx_j)));
        last_pair = (k_q == KW'(PAIRS - 1));
        accept    = in_valid & in_ready;
    end

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        acc_d   = acc_q;
        p_d     = p_q;
        k_d     = k_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StCalc;
                end
            end
            StCalc: begin
                acc_d = sum;
                k_d   = k_q + KW'(1);
                if (last_pair) begin
                    p_d     = sum;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = accept ? StCalc : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (accept) begin
            ra_d  = a;
            rb_d  = b;
            acc_d = '0;
            k_d   = '0;
        end
    end

    always_comb begin
`ifdef VEDIC_SEQ_BACK2BACK_EN
        in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
`else
        in_ready  = (state_q == StIdle);
`endif
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        p         = p_q;
    end
endmodule

// File: doc/vedic_seq_mul8.md
Name: vedic_seq_mul8

Overview:
- Sequential, handshaked multiplier that time-multiplexes one 4x4 Vedic core (vedic4mul) over the 4-bit nibbles of wider operands.
- Sits directly upstream of, and around, vedic4mul:
  - feeds it one nibble pair per cycle;
  - consumes its 8-bit product into a shifted accumulator.
- Gives the datapath an OP_W x OP_W product with valid/ready flow control, using one 4x4 core instead of (OP_W/4)^2.

Parameters:
- OP_W, 8, operand width. Legal values: 4, 8, 12, 16 (multiple of 4). NIB = OP_W/4 nibbles per operand.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands a/b valid
- in_ready  out  1  block can accept operands
- a  in  OP_W  multiplicand, unsigned
- b  in  OP_W  multiplier, unsigned
- out_valid  out  1  product p valid
- out_ready  in  1  consumer accepts p
- p  out  2*OP_W  unsigned product a*b
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset:
  - One clock (clk); reset is asynchronous, active-low (rst_n); all flops clear immediately on rst_n=0.
  - After reset: state=IDLE, in_ready=1, out_valid=0, p=0, busy=0, accumulator=0, pair counter k=0.
- State machine, three states:
  - IDLE:
    - in_ready=1.
    - On in_valid&in_ready: register a→ra and b→rb, clear acc, k=0, go to CALC.
  - CALC:
    - in_ready=0.
    - Each cycle: i=k mod NIB, j=k div NIB; drive vedic4mul with ra[4i+3:4i] and rb[4j+3:4j].
    - acc <= acc + (prod8 << 4*(i+j)), with acc 2*OP_W bits wide.
    - k increments by 1 each cycle.
    - On the edge that adds pair k=NIB*NIB-1: p <= final sum, out_valid <= 1, go to DONE.
  - DONE:
    - out_valid=1, p held stable.
    - On out_ready=1: out_valid <= 0, go to IDLE.
- Latency and throughput:
  - out_valid rises NIB*NIB clocks after the acceptance edge (OP_W=8: 4 clocks).
  - Throughput without the optional feature: one product per NIB*NIB+2 clocks when out_ready is held high.
- Arithmetic: intermediate sums never exceed the final product, so no overflow/truncation logic is needed.
- Operand stability: a/b changes after acceptance have no effect (ra/rb captured). in_valid while in CALC/DONE is ignored; the upstream producer must hold it.
- Output register: p is updated only on entry to DONE and keeps its last value in IDLE until the next result.
- rst_n low mid-CALC or in DONE: in-flight operation discarded, outputs return to reset values, no partial result is ever presented.
- Handshake rules:
  - out_valid never drops without out_ready.
  - p never changes while out_valid=1.
  - in_ready is a function of state only (plus out_ready when the optional feature is compiled in).
- OP_W=4: single CALC cycle; p = core product.

Optional Feature:
- Macro VEDIC_SEQ_BACK2BACK_EN.
- Defined:
  - In DONE, in_ready = out_ready.
  - A same-cycle out handshake plus in_valid captures new operands, clears acc and goes directly to CALC.
  - Sustained throughput: one product per NIB*NIB+1 clocks.
- Undefined: in_ready asserted only in IDLE; one bubble cycle between results.

Test Plan:
- OP_W=8, a=0x12, b=0x34, out_ready=1 → out_valid exactly 4 clocks after accept, p=0x03A8, busy high for 5 cycles.
- a=0xFF, b=0xFF → p=0xFE01. Then a=0x00, b=0xA5 → p=0x0000. Then a=0x80, b=0x02 → p=0x0100.
- Backpressure: result 0x0C*0x0D with out_ready low 10 clocks → p=0x009C stable, out_valid held, in_ready=0, a second in_valid ignored until handshake.
- Reset: rst_n pulsed low during 2nd CALC cycle of 0xAB*0xCD → outputs to reset values asynchronously. Next operation 0x03*0x05 → p=0x000F, no stale accumulation.
- Throughput with continuous in_valid/out_ready=1: 3 results spaced 6 clocks (macro off) and 5 clocks (VEDIC_SEQ_BACK2BACK_EN on), all products correct.
- Exhaustive 65536-pair random-stall sweep at OP_W=8, plus 1000 random pairs at OP_W=16 (e.g. 0xFFFF*0xFFFF=0xFFFE0001) against a golden model.
